menu_fsm_n: RTL and testbench
=============================

MENU_FSM_N -- requirements
Module: menu_fsm_n

Interface
REQ-001 SHALL have parameter N_ITEMS, default 3; number of menu items. Items 0..N_ITEMS-2 are games; item N_ITEMS-1 is Exit; legal range 2..16.
REQ-002 SHALL have parameter SEL_W, default 2; width of the cursor and of vgaMUX; 2**SEL_W >= N_ITEMS.
REQ-003 SHALL have parameter HOLD_CYC, default 4; button hold-off length in cycles after any menu/game transition; legal range 0..255.
REQ-004 SHALL have port sys_clk, input, 1 bit; the single clock; all logic on its rising edge.
REQ-005 SHALL have port sys_rst_n, input, 1 bit; reset, synchronous and active-high despite the name (one clock; reset is synchronous and active-high).
REQ-006 SHALL have ports button_up and button_down, input, 1 bit each; level inputs; cursor previous/next.
REQ-007 SHALL have port button_right, input, 1 bit; level input; confirm.
REQ-008 SHALL have port game_exit, input, 1 bit; level input; request from the running game to return to the menu.
REQ-009 SHALL have port choice, output, SEL_W bits; current cursor index.
REQ-010 SHALL have port vgaMUX, output, SEL_W bits; 0 = menu background, k+1 = game k running.
REQ-011 SHALL have port in_game, output, 1 bit; high while a game runs.
REQ-012 SHALL have port halted, output, 1 bit; high once Exit is confirmed.

Function
REQ-013 SHALL use three states: MENU, GAME, HALT; cursor register cur[SEL_W-1:0]; hold-off counter hold[7:0].
REQ-014 SHALL register each button every cycle into prev_*; an event is btn & ~prev_btn, i.e. rising-edge only; holding a button yields one event.
REQ-015 SHALL apply button events only in MENU and only when hold==0; events arriving otherwise are discarded, not queued.
REQ-016 SHALL, for simultaneous events in MENU, use priority down > up > right; only one event takes effect per cycle.
REQ-017 MENU, down event: cur <= (cur==N_ITEMS-1) ? 0 : cur+1 (wrap).
REQ-018 MENU, up event: cur <= (cur==0) ? N_ITEMS-1 : cur-1 (wrap).
REQ-019 MENU, right event with cur<N_ITEMS-1: go to GAME, cur unchanged, hold <= HOLD_CYC.
REQ-020 MENU, right event with cur==N_ITEMS-1: go to HALT.
REQ-021 GAME: game_exit high while hold==0 returns to MENU with cur preserved (cursor stays on the game just left), hold <= HOLD_CYC; buttons are ignored.
REQ-022 HALT SHALL be absorbing; only reset leaves it.
REQ-023 hold SHALL decrement by 1 each cycle while nonzero, saturating at 0; with HOLD_CYC=0 there is no hold-off.
REQ-024 Outputs SHALL be Moore outputs of registered state: choice=cur in every state; vgaMUX=cur+1 in GAME, else 0; in_game=(state==GAME); halted=(state==HALT).
REQ-025 Outputs SHALL reflect an accepted event from the clock edge that samples it, i.e. visible one cycle after the button is first seen high.
REQ-026 SHALL treat cur as always in 0..N_ITEMS-1; any other value is corrected to 0 on the next edge.

Reset
REQ-027 With sys_rst_n=1 at a rising edge, the block SHALL set state=MENU, cur=0, hold=0, and all prev_* to 1; outputs then read choice=0, vgaMUX=0, in_game=0, halted=0.
REQ-028 Setting prev_* to 1 SHALL ensure a button held through reset produces no event until released and pressed again.
REQ-029 Reset SHALL take priority over every other input in any state, including mid hold-off and HALT.

Verification (N_ITEMS=3, SEL_W=2, HOLD_CYC=4)
REQ-030 Test: after reset, three single-cycle down pulses -> choice 1, 2, 0 (wrap); then one up pulse -> choice 2.
REQ-031 Test: down held 10 cycles -> choice advances exactly once, 0 -> 1.
REQ-032 Test: choice=1, right pulse -> vgaMUX=2, in_game=1; game_exit high on the following 3 cycles -> ignored; game_exit on the 5th cycle -> vgaMUX=0, in_game=0, choice=1.
REQ-033 Test: up, down, and right rise in the same cycle from choice=0 -> choice=1 only, no game entered.
REQ-034 Test: choice=2, right pulse -> halted=1; further button and game_exit activity -> no change; reset -> all outputs 0.
REQ-035 Test: right held across reset while in GAME -> MENU, choice=0, no game entry until right is released and pressed again.

Source files
------------

// File: rtl/menu_fsm_n.sv
// Menu controller: a cursor steps through N_ITEMS entries, confirming one either
// starts a game or halts the system. A hold-off counter swallows stray presses.
module menu_fsm_n #(
  parameter int N_ITEMS  = 3,
  parameter int SEL_W    = 2,
  parameter int HOLD_CYC = 4
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             button_up,
  input  logic             button_down,
  input  logic             button_right,
  input  logic             game_exit,
  output logic [SEL_W-1:0] choice,
  output logic [SEL_W-1:0] vgaMUX,
  output logic             in_game,
  output logic             halted
);

  typedef enum logic [1:0] {
    MENU = 2'd0,
    GAME = 2'd1,
    HALT = 2'd2
  } state_t;

  localparam logic [SEL_W-1:0] LAST      = SEL_W'(N_ITEMS - 1);
  localparam logic [7:0]       HOLD_INIT = 8'(HOLD_CYC);

  state_t           state, state_next;
  logic [SEL_W-1:0] cur, cur_next;
  logic [7:0]       hold, hold_next;
  logic             prev_up, prev_down, prev_right;
  logic             ev_up, ev_down, ev_right;
  logic             accept;

  assign ev_up    = button_up    & ~prev_up;
  assign ev_down  = button_down  & ~prev_down;
  assign ev_right = button_right & ~prev_right;
  assign accept   = (state == MENU) && (hold == 8'd0);

  // The reset input is active-high despite its name. prev_* come up as 1 so a
  // button held through reset must be released before it can fire.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge sys_clk) begin
    if (sys_rst_n) begin
      state      <= MENU;
      cur        <= '0;
      hold       <= 8'd0;
      prev_up    <= 1'b1;
      prev_down  <= 1'b1;
      prev_right <= 1'b1;
    end else begin
      state      <= state_next;
      cur        <= cur_next;
      hold       <= hold_next;
      prev_up    <= button_up;
      prev_down  <= button_down;
      prev_right <= button_right;
    end
  end

  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    cur_next   = cur;
    hold_next  = (hold != 8'd0) ? hold - 8'd1 : hold;

    unique case (state)
      MENU: begin
        if (accept) begin
          if (ev_down) begin
            cur_next = (cur == LAST) ? '0 : cur + 1'b1;
          end else if (ev_up) begin
            cur_next = (cur == '0) ? LAST : cur - 1'b1;
          end else if (ev_right) begin
            if (cur == LAST) begin
              state_next = HALT;
            end else begin
              state_next = GAME;
              hold_next  = HOLD_INIT;
            end
          end
        end
      end
      GAME: begin
        if (game_exit && (hold == 8'd0)) begin
          state_next = MENU;
          hold_next  = HOLD_INIT;
        end
      end
      HALT: begin
      end
      default: begin
        state_next = MENU;
      end
    endcase

    // Out-of-range cursor values self-correct rather than persist.
    if (cur > LAST) begin
      cur_next = '0;
    end
  end

  always_comb begin
    choice  = cur;
    vgaMUX  = '0;
    in_game = 1'b0;
    halted  = 1'b0;
    unique case (state)
      GAME: begin
        vgaMUX  = cur + 1'b1;
        in_game = 1'b1;
      end
      HALT: begin
        halted = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_menu_fsm_n.sv
// Bench for menu_fsm_n: directed stimulus queues expected outputs stamped with
// the clock edge they belong to; a monitor pops and compares after each edge.
module tb_menu_fsm_n;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b1;
  logic       button_up = 1'b0;
  logic       button_down = 1'b0;
  logic       button_right = 1'b0;
  logic       game_exit = 1'b0;
  logic [1:0] choice;
  logic [1:0] vgaMUX;
  logic       in_game;
  logic       halted;

  always #5 sys_clk = ~sys_clk;

  menu_fsm_n #(.N_ITEMS(3), .SEL_W(2), .HOLD_CYC(4)) dut (
    .sys_clk      (sys_clk),
    .sys_rst_n    (sys_rst_n),
    .button_up    (button_up),
    .button_down  (button_down),
    .button_right (button_right),
    .game_exit    (game_exit),
    .choice       (choice),
    .vgaMUX       (vgaMUX),
    .in_game      (in_game),
    .halted       (halted)
  );

  typedef struct packed {
    int         cyc;
    logic [1:0] choice;
    logic [1:0] vga;
    logic       in_game;
    logic       halted;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    cyc = 0;
  int    n_vec = 0;
  int    n_err = 0;

  always @(posedge sys_clk) cyc <= cyc + 1;

  // Monitor: compare every expectation due at this edge.
  always @(posedge sys_clk) begin
    exp_t  e;
    string nm;
    #1;
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      n_vec++;
      if (e.cyc != cyc || choice !== e.choice || vgaMUX !== e.vga ||
          in_game !== e.in_game || halted !== e.halted) begin
        n_err++;
        $display("FAIL %s @cyc %0d: got choice=%0d vga=%0d in_game=%0b halted=%0b, want choice=%0d vga=%0d in_game=%0b halted=%0b",
                 nm, cyc, choice, vgaMUX, in_game, halted,
                 e.choice, e.vga, e.in_game, e.halted);
      end
    end
  end

  task automatic step(input logic up, input logic dn, input logic rt, input logic ex);
    @(negedge sys_clk);
    button_up    = up;
    button_down  = dn;
    button_right = rt;
    game_exit    = ex;
  endtask

  // Expected outputs right after the next rising edge.
  task automatic chk(input string nm, input logic [1:0] ch, input logic [1:0] vg,
                     input logic ig, input logic hl);
    exp_t e;
    e.cyc     = cyc + 1;
    e.choice  = ch;
    e.vga     = vg;
    e.in_game = ig;
    e.halted  = hl;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic do_reset(input logic rt);
    @(negedge sys_clk);
    sys_rst_n    = 1'b1;
    button_up    = 1'b0;
    button_down  = 1'b0;
    button_right = rt;
    game_exit    = 1'b0;
    chk("reset", 2'd0, 2'd0, 1'b0, 1'b0);
    @(negedge sys_clk);
    sys_rst_n = 1'b0;
  endtask

  initial begin
    // Cursor wrap in both directions.
    do_reset(1'b0);
    step(0, 1, 0, 0); chk("down_1", 2'd1, 2'd0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 1, 0, 0); chk("down_2", 2'd2, 2'd0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 1, 0, 0); chk("down_wrap", 2'd0, 2'd0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(1, 0, 0, 0); chk("up_wrap", 2'd2, 2'd0, 0, 0);
    step(0, 0, 0, 0);

    // Held button advances exactly once.
    do_reset(1'b0);
    for (int i = 0; i < 10; i++) begin
      step(0, 1, 0, 0); chk("down_held", 2'd1, 2'd0, 0, 0);
    end
    step(0, 0, 0, 0); chk("down_release", 2'd1, 2'd0, 0, 0);

    // Game entry, exit hold-off, then menu hold-off.
    step(0, 0, 1, 0); chk("game_enter", 2'd1, 2'd2, 1, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 1); chk("exit_held_off", 2'd1, 2'd2, 1, 0);
    end
    step(0, 0, 0, 0); chk("game_hold_last", 2'd1, 2'd2, 1, 0);
    step(0, 0, 0, 1); chk("game_exit", 2'd1, 2'd0, 0, 0);
    step(0, 1, 0, 0); chk("menu_hold_drop", 2'd1, 2'd0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 1, 0, 0); chk("menu_hold_done", 2'd2, 2'd0, 0, 0);
    step(0, 0, 0, 0);

    // Simultaneous events: down wins.
    do_reset(1'b0);
    step(1, 1, 1, 0); chk("simul_down", 2'd1, 2'd0, 0, 0);
    step(0, 0, 0, 0); chk("simul_no_game", 2'd1, 2'd0, 0, 0);

    // Exit item halts; HALT is absorbing until reset.
    step(0, 1, 0, 0); chk("to_exit_item", 2'd2, 2'd0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 1, 0); chk("halt", 2'd2, 2'd0, 0, 1);
    step(1, 1, 1, 1); chk("halt_stuck_a", 2'd2, 2'd0, 0, 1);
    step(0, 0, 0, 0);
    step(0, 1, 0, 1); chk("halt_stuck_b", 2'd2, 2'd0, 0, 1);
    do_reset(1'b0);
    step(0, 0, 0, 0);

    // Right held across reset from GAME needs release and re-press.
    step(0, 0, 1, 0); chk("game_item0", 2'd0, 2'd1, 1, 0);
    do_reset(1'b1);
    chk("rst_right_held", 2'd0, 2'd0, 0, 0);
    step(0, 0, 1, 0); chk("right_still_held", 2'd0, 2'd0, 0, 0);
    step(0, 0, 0, 0); chk("right_released", 2'd0, 2'd0, 0, 0);
    step(0, 0, 1, 0); chk("right_repress", 2'd0, 2'd1, 1, 0);
    step(0, 0, 0, 0);

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge sys_clk);
    #2;
    if (exp_q.size() != 0) begin
      $display("FAIL drain: %0d expectations never checked, want 0", exp_q.size());
      n_err += exp_q.size();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
